vector_normalizer: RTL and testbench
====================================

VECTOR_NORMALIZER -- requirements
Module: vector_normalizer

Interface
REQ-001 Parameter LANES, default 4: parallel data lanes per beat.
REQ-002 Parameter NUM_CH, default 8: entries in the per-channel gain/bias/shift table; CH_W = clog2(NUM_CH).
REQ-003 Parameter OUT_W, default 16: signed output width per lane, range 8..32.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset; assertion is immediate, deassertion is synchronous to clk.
REQ-006 Port in_valid / in_ready, input / output, 1 / 1: input handshake; a beat transfers when both are high on a clk edge.
REQ-007 Port in_data, input, LANES*32: signed 32-bit lanes, lane 0 in the LSBs.
REQ-008 Port in_ch, input, CH_W: table index applied to all lanes of the beat.
REQ-009 Port out_valid / out_ready, output / input, 1 / 1: output handshake.
REQ-010 Port out_data, output, LANES*OUT_W: normalized signed lanes, lane 0 in the LSBs.
REQ-011 Port out_sat, output, LANES: per-lane flag, high when that lane was clamped.
REQ-012 Port cfg_we, cfg_addr (CH_W), cfg_gain (16 signed), cfg_bias (32 signed), cfg_shift (5), cfg_round (1), all inputs: table write port.
REQ-013 Port sat_count, output, 16: count of beats with any lane saturated; port sat_clr, input, 1: clears it.

Function
REQ-014 Per lane, the block SHALL compute y = sat_OUT_W(((x*gain) + rnd) >>> shift + bias), using the table entry selected by in_ch.
REQ-015 x*gain SHALL be a full-precision signed 48-bit product; rnd = 2^(shift-1) when round=1 and shift>0, else 0; rnd add, shift and bias add SHALL be done in 49-bit signed arithmetic with no intermediate truncation.
REQ-016 sat_OUT_W SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat for that lane when clamping occurs.
REQ-017 Pipeline: S1 captures the beat and reads the table; S2 multiplies; S3 rounds, shifts, adds bias and saturates into the output register.
REQ-018 Latency SHALL be exactly 3 cycles from input transfer to out_valid with no backpressure; throughput SHALL be 1 beat/cycle.
REQ-019 All stages SHALL advance together under enable = !out_valid || out_ready; in_ready SHALL equal enable (combinational).
REQ-020 While out_valid=1 and out_ready=0, out_data, out_sat and out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-021 Bubbles (in_valid=0 on an enabled cycle) SHALL propagate as invalid stage slots.
REQ-022 Table writes SHALL take effect on the next edge regardless of stalls; a beat captured in the same cycle as a write to its channel SHALL use the old entry.
REQ-023 Parameters captured with a beat in S1 SHALL travel with that beat; later table writes SHALL NOT affect beats in flight.
REQ-024 sat_count SHALL increment by 1 on each output transfer where any out_sat bit is high, saturate at 16'hFFFF, and clear on sat_clr; sat_clr takes priority over a simultaneous increment.
REQ-025 in_ch >= NUM_CH (non-power-of-two NUM_CH) SHALL use table entry 0.

Reset
REQ-026 While reset_n=0: all stage valids, out_valid, out_data, out_sat and sat_count SHALL be 0, and in_ready SHALL be 0.
REQ-027 On reset, every table entry SHALL be gain=16'sd1, bias=0, shift=0, round=0, making the block a saturating pass-through.
REQ-028 Reset assertion mid-stream SHALL discard all in-flight beats; the first beat after release SHALL see reset table values unless the table is rewritten.

Verification
REQ-029 After reset, with OUT_W=16 and a beat of lanes {100, -100, 40000, -40000} on ch 0 -> 3 cycles later {100, -100, 32767, -32768}, out_sat=4'b1100, sat_count=1.
REQ-030 ch 2 configured gain=3, shift=2, round=1, bias=10; lane x=5 -> (15+2)>>>2 +10 = 14; with round=0 -> 13; x=-5 with round=1 -> -4+10 = 6.
REQ-031 Stream 10 back-to-back beats, out_ready low on cycles 4..7 -> all 10 outputs appear in order, values held while stalled, in_ready low on exactly the stall cycles.
REQ-032 Write ch 1 gain=2 in the same cycle a beat on ch 1 is accepted -> that beat uses gain=1; the next beat uses gain=2.
REQ-033 Pull reset_n low with 3 beats in flight -> out_valid drops immediately, no stale beats emerge after release, and the table returns to its reset values.
REQ-034 Force 65536 saturating beats -> sat_count holds at 65535; assert sat_clr together with a saturating transfer -> sat_count=0.

Source files
------------

// File: rtl/vector_normalizer.sv
// Multi-lane affine normalizer: y = sat(((x*gain + rnd) >>> shift) + bias) per lane,
// using a per-channel parameter table, in a 3-stage pipeline with a global stall.
module vector_normalizer #(
    parameter int LANES  = 4,
    parameter int NUM_CH = 8,
    parameter int OUT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*32-1:0]      in_data,
    input  logic [CH_W-1:0]          in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_addr,
    input  logic signed [15:0]       cfg_gain,
    input  logic signed [31:0]       cfg_bias,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_round,
    output logic [15:0]              sat_count,
    input  logic                     sat_clr
);

    localparam logic signed [48:0] SAT_MAX = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
    localparam logic signed [48:0] SAT_MIN = -(49'sd1 <<< (OUT_W - 1));
    localparam logic [OUT_W-1:0]   MAX_Y   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   MIN_Y   = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [15:0] tbl_gain_reg  [NUM_CH];
    logic signed [31:0] tbl_bias_reg  [NUM_CH];
    logic [4:0]         tbl_shift_reg [NUM_CH];
    logic               tbl_round_reg [NUM_CH];

    logic                    s1_valid_reg;
    logic [LANES*32-1:0]     s1_data_reg;
    logic signed [15:0]      s1_gain_reg;
    logic signed [31:0]      s1_bias_reg;
    logic [4:0]              s1_shift_reg;
    logic                    s1_round_reg;

    logic                    s2_valid_reg;
    logic [LANES*48-1:0]     s2_prod_reg;
    logic signed [31:0]      s2_bias_reg;
    logic [4:0]              s2_shift_reg;
    logic                    s2_round_reg;

    logic                    out_valid_reg;
    logic [LANES*OUT_W-1:0]  out_data_reg;
    logic [LANES-1:0]        out_sat_reg;
    logic [15:0]             sat_count_reg;

    logic                    enable;
    logic [CH_W-1:0]         ch_sel;
    logic [LANES*48-1:0]     prod_next;
    logic [LANES*OUT_W-1:0]  y_next;
    logic [LANES-1:0]        sat_next;
    logic signed [48:0]      rnd_add;

    assign enable    = !out_valid_reg || out_ready;
    assign in_ready  = reset_n && enable;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign sat_count = sat_count_reg;

    // Out-of-range channels fall back to entry 0.
    assign ch_sel  = (32'(in_ch) < NUM_CH) ? in_ch : '0;
    assign rnd_add = (s2_round_reg && s2_shift_reg != 5'd0) ?
                     (49'sd1 <<< (s2_shift_reg - 5'd1)) : 49'sd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tbl_gain_reg[i]  <= 16'sd1;
                tbl_bias_reg[i]  <= 32'sd0;
                tbl_shift_reg[i] <= 5'd0;
                tbl_round_reg[i] <= 1'b0;
            end
        end else if (cfg_we && (32'(cfg_addr) < NUM_CH)) begin
            tbl_gain_reg[cfg_addr]  <= cfg_gain;
            tbl_bias_reg[cfg_addr]  <= cfg_bias;
            tbl_shift_reg[cfg_addr] <= cfg_shift;
            tbl_round_reg[cfg_addr] <= cfg_round;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [31:0] x;
            logic signed [47:0] prod;
            logic signed [48:0] rounded;
            logic signed [48:0] shifted;
            logic signed [48:0] biased;
            logic               sat_hi;
            logic               sat_lo;

            assign x        = s1_data_reg[gi*32 +: 32];
            assign prod_next[gi*48 +: 48] = 48'(x) * 48'(s1_gain_reg);

            assign prod     = s2_prod_reg[gi*48 +: 48];
            assign rounded  = 49'(prod) + rnd_add;
            assign shifted  = rounded >>> s2_shift_reg;
            assign biased   = shifted + 49'(s2_bias_reg);
            assign sat_hi   = biased > SAT_MAX;
            assign sat_lo   = biased < SAT_MIN;

            assign y_next[gi*OUT_W +: OUT_W] = sat_hi ? MAX_Y :
                                               sat_lo ? MIN_Y : biased[OUT_W-1:0];
            assign sat_next[gi] = s2_valid_reg && (sat_hi || sat_lo);
        end
    endgenerate

    // One enable moves every stage, so stalled beats neither drop nor duplicate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_gain_reg   <= 16'sd0;
            s1_bias_reg   <= 32'sd0;
            s1_shift_reg  <= 5'd0;
            s1_round_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_prod_reg   <= '0;
            s2_bias_reg   <= 32'sd0;
            s2_shift_reg  <= 5'd0;
            s2_round_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= '0;
        end else if (enable) begin
            s1_valid_reg  <= in_valid;
            s1_data_reg   <= in_data;
            s1_gain_reg   <= tbl_gain_reg[ch_sel];
            s1_bias_reg   <= tbl_bias_reg[ch_sel];
            s1_shift_reg  <= tbl_shift_reg[ch_sel];
            s1_round_reg  <= tbl_round_reg[ch_sel];
            s2_valid_reg  <= s1_valid_reg;
            s2_prod_reg   <= prod_next;
            s2_bias_reg   <= s1_bias_reg;
            s2_shift_reg  <= s1_shift_reg;
            s2_round_reg  <= s1_round_reg;
            out_valid_reg <= s2_valid_reg;
            out_data_reg  <= y_next;
            out_sat_reg   <= sat_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count_reg <= 16'd0;
        end else if (sat_clr) begin
            sat_count_reg <= 16'd0;
        end else if (out_valid_reg && out_ready && (|out_sat_reg) &&
                     sat_count_reg != 16'hFFFF) begin
            sat_count_reg <= sat_count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_vector_normalizer.sv
// Directed bench for vector_normalizer: hand-computed vectors, immediate assertions.
module tb_vector_normalizer;

    localparam int LANES = 4;
    localparam int OUT_W = 16;
    localparam int CH_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*32-1:0]     in_data;
    logic [CH_W-1:0]         in_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*OUT_W-1:0]  out_data;
    logic [LANES-1:0]        out_sat;
    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_addr;
    logic signed [15:0]      cfg_gain;
    logic signed [31:0]      cfg_bias;
    logic [4:0]              cfg_shift;
    logic                    cfg_round;
    logic [15:0]             sat_count;
    logic                    sat_clr;

    int checks   = 0;
    int failures = 0;

    vector_normalizer #(.LANES(LANES), .NUM_CH(8), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift), .cfg_round(cfg_round),
        .sat_count(sat_count), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] exp4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic set_cfg(input int ch, input int gain, input int bias, input int shift,
                           input int rnd);
        cfg_we    = 1'b1;
        cfg_addr  = CH_W'(ch);
        cfg_gain  = 16'(gain);
        cfg_bias  = 32'(bias);
        cfg_shift = 5'(shift);
        cfg_round = rnd[0];
    endtask

    task automatic send(input int ch, input int a, input int b, input int c, input int d);
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = pack4(a, b, c, d);
    endtask

    initial begin
        int sent;
        int rcv;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_gain = '0; cfg_bias = '0; cfg_shift = '0;
        cfg_round = 1'b0; sat_clr = 1'b0;
        tick(); tick();

        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_sat_count", 64'(sat_count), 64'd0);

        reset_n = 1'b1;
        tick();
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Pass-through with clamping on channel 0.
        send(0, 100, -100, 40000, -40000);
        tick();
        in_valid = 1'b0;
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_c2_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_c3_valid", 64'(out_valid), 64'd1);
        check("clamp_data", 64'(out_data), exp4(100, -100, 32767, -32768));
        check("clamp_sat", 64'(out_sat), 64'b1100);
        tick();
        check("clamp_sat_count", 64'(sat_count), 64'd1);
        check("clamp_drained", 64'(out_valid), 64'd0);

        // Rounding/shift/bias; second write to ch 2 lands with beat A, so A keeps round=1.
        set_cfg(2, 3, 10, 2, 1);
        tick();
        set_cfg(2, 3, 10, 2, 0);
        send(2, 5, -5, 0, -6);
        tick();
        cfg_we = 1'b0;
        send(2, 5, -5, 0, -6);
        tick();
        in_valid = 1'b0;
        tick();
        check("round1_data", 64'(out_data), exp4(14, 6, 10, 6));
        check("round1_sat", 64'(out_sat), 64'd0);
        tick();
        check("round0_data", 64'(out_data), exp4(13, 6, 10, 5));

        // Write racing with a beat on the same channel.
        set_cfg(1, 2, 0, 0, 0);
        send(1, 1000, -3, 20000, 0);
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("race_old_gain", 64'(out_data), exp4(1000, -3, 20000, 0));
        tick();
        check("race_new_gain", 64'(out_data), exp4(2000, -6, 32767, 0));
        check("race_new_sat", 64'(out_sat), 64'b0100);
        tick();
        check("race_sat_count", 64'(sat_count), 64'd2);

        // Ten back-to-back beats with out_ready low on cycles 4..7.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 10) send(0, sent * 10 + 1, -sent, sent * 1000, 7);
            else in_valid = 1'b0;
            #1;
            check($sformatf("stream_in_ready_c%0d", cyc), 64'(in_ready),
                  64'(!(cyc >= 4 && cyc <= 7)));
            if (out_valid) begin
                check($sformatf("stream_data_b%0d_c%0d", rcv, cyc), 64'(out_data),
                      exp4(rcv * 10 + 1, -rcv, rcv * 1000, 7));
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(rcv), 64'd10);

        // Reset with three beats in flight, after altering ch 0.
        set_cfg(0, 5, 0, 0, 0);
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, 1, 2, 3, 4);
            tick();
        end
        in_valid = 1'b0;
        check("midrst_valid_before", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid_drop", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("midrst_no_stale_%0d", i), 64'(out_valid), 64'd0);
        end
        send(0, 1, 2, 3, 4);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("midrst_table_reset", 64'(out_data), exp4(1, 2, 3, 4));
        tick();

        // sat_count saturation over 65536 saturating beats.
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("satcnt_cleared", 64'(sat_count), 64'd0);
        send(0, 40000, 0, 0, 0);
        for (int i = 0; i < 65536; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("satcnt_hold", 64'(sat_count), 64'hFFFF);

        // Clear coinciding with a saturating transfer, from full and from zero.
        send(0, -40000, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("clr_pending_valid", 64'(out_valid), 64'd1);
        check("clr_pending_count", 64'(sat_count), 64'hFFFF);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("clr_from_full", 64'(sat_count), 64'd0);
        send(0, -40000, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("clr_zero_sat", 64'(out_sat), 64'b0001);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("clr_priority", 64'(sat_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
